// File: rtl/hamming_uart_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_uart_scheduler_if
//  Description : Bundle between the requesters, the Hamming(7,4) encoder, the
//                UART transmitter and the round-robin frame scheduler.
//                slave  = scheduler side, master = surrounding system side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hamming_uart_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int c_ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // requester side
    logic [NUM_REQ-1:0]   req;
    logic [4*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   err;
    // encoder side
    logic                 enc_ena;
    logic [3:0]           enc_data;
    logic                 enc_valid;
    // transmitter side
    logic                 tx_start;
    logic                 tx_busy;
    // status
    logic [c_ID_W-1:0]    grant_id;
    logic                 busy;
    logic [7:0]           frame_count;

    modport slave (
        input  req, req_data, enc_valid, tx_busy,
        output ack, err, enc_ena, enc_data, tx_start, grant_id, busy, frame_count
    );

    modport master (
        output req, req_data, enc_valid, tx_busy,
        input  ack, err, enc_ena, enc_data, tx_start, grant_id, busy, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/hamming_uart_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_uart_scheduler
//  Description : Round-robin scheduler sharing one Hamming(7,4) encoder and
//                one UART transmitter among NUM_REQ nibble requesters. Grants
//                a requester, pulses the encoder, starts the transmitter on
//                the encoder valid rising edge, waits for the frame to finish
//                and returns a per-requester ack (done) or err (timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
module hamming_uart_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 15,
    parameter int GAP_CYCLES = 2
) (
    input wire logic                   clk,
    input wire logic                   rst,
    hamming_uart_scheduler_if.slave    sched_bus
);

    localparam int c_ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] c_IDLE         = 3'd0;
    localparam logic [2:0] c_ENCODE       = 3'd1;
    localparam logic [2:0] c_WAIT_VALID   = 3'd2;
    localparam logic [2:0] c_START_TX     = 3'd3;
    localparam logic [2:0] c_WAIT_BUSY_HI = 3'd4;
    localparam logic [2:0] c_WAIT_BUSY_LO = 3'd5;
    localparam logic [2:0] c_GAP          = 3'd6;

    // Where a finished or aborted frame goes: straight to IDLE when no gap.
    localparam logic [2:0]        c_AFTER_FRAME = (GAP_CYCLES == 0) ? c_IDLE : c_GAP;
    localparam logic [7:0]        c_TMO_LAST    = 8'(TIMEOUT - 1);
    localparam logic [3:0]        c_GAP_LAST    = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam logic [c_ID_W-1:0] c_LAST_INIT   = c_ID_W'(NUM_REQ - 1);

    logic [2:0]         r_state;
    logic [7:0]         r_timer;
    logic [3:0]         r_gap;
    logic [c_ID_W-1:0]  r_last;
    logic               r_valid_d;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_err;
    logic               r_enc_ena;
    logic [3:0]         r_enc_data;
    logic               r_tx_start;
    logic [c_ID_W-1:0]  r_grant_id;
    logic [7:0]         r_frame_count;

    logic               w_vrise;
    logic               w_found;
    logic [c_ID_W-1:0]  w_pick;
    logic [c_ID_W-1:0]  w_idx;

    // Only a fresh low-to-high transition of valid counts as encoder completion.
    assign w_vrise = sched_bus.enc_valid & ~r_valid_d;

    // Round-robin search: first pending request starting just after the last grant.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = c_ID_W'((int'(r_last) + i) % NUM_REQ);
            if (!w_found && sched_bus.req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Frame sequencing FSM with registered pulse and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_timer       <= '0;
            r_gap         <= '0;
            r_last        <= c_LAST_INIT;
            r_valid_d     <= 1'b0;
            r_ack         <= '0;
            r_err         <= '0;
            r_enc_ena     <= 1'b0;
            r_enc_data    <= '0;
            r_tx_start    <= 1'b0;
            r_grant_id    <= '0;
            r_frame_count <= '0;
        end else begin
            r_valid_d  <= sched_bus.enc_valid;
            r_enc_ena  <= 1'b0;
            r_tx_start <= 1'b0;
            r_ack      <= '0;
            r_err      <= '0;

            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_pick;
                        r_enc_data <= sched_bus.req_data[{w_pick, 2'b00} +: 4];
                        r_last     <= w_pick;
                        r_enc_ena  <= 1'b1;
                        r_state    <= c_ENCODE;
                    end
                end

                c_ENCODE: begin
                    r_timer <= '0;
                    r_state <= c_WAIT_VALID;
                end

                c_WAIT_VALID: begin
                    if (w_vrise) begin
                        r_tx_start <= 1'b1;
                        r_state    <= c_START_TX;
                    end else if (r_timer == c_TMO_LAST) begin
                        r_err[r_grant_id] <= 1'b1;
                        r_gap             <= '0;
                        r_state           <= c_AFTER_FRAME;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end

                c_START_TX: begin
                    r_timer <= '0;
                    r_state <= c_WAIT_BUSY_HI;
                end

                c_WAIT_BUSY_HI: begin
                    if (sched_bus.tx_busy) begin
                        r_state <= c_WAIT_BUSY_LO;
                    end else if (r_timer == c_TMO_LAST) begin
                        r_err[r_grant_id] <= 1'b1;
                        r_gap             <= '0;
                        r_state           <= c_AFTER_FRAME;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end

                // A frame that has started transmitting always runs to completion.
                c_WAIT_BUSY_LO: begin
                    if (!sched_bus.tx_busy) begin
                        r_ack[r_grant_id] <= 1'b1;
                        r_frame_count     <= r_frame_count + 8'd1;
                        r_gap             <= '0;
                        r_state           <= c_AFTER_FRAME;
                    end
                end

                c_GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_gap <= r_gap + 4'd1;
                    end
                end

                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign sched_bus.ack         = r_ack;
    assign sched_bus.err         = r_err;
    assign sched_bus.enc_ena     = r_enc_ena;
    assign sched_bus.enc_data    = r_enc_data;
    assign sched_bus.tx_start    = r_tx_start;
    assign sched_bus.grant_id    = r_grant_id;
    assign sched_bus.busy        = (r_state != c_IDLE);
    assign sched_bus.frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_hamming_uart_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hamming_uart_scheduler
//  Description : Self-checking bench for hamming_uart_scheduler with encoder
//                and UART behavioural models and an expectation queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_uart_scheduler;

    localparam int NUM_REQ    = 4;
    localparam int TIMEOUT    = 15;
    localparam int GAP_CYCLES = 2;

    typedef struct {
        int         id;
        logic [3:0] nib;
        bit         is_err;
        int         lat;      // 0: ack path, 1: encoder timeout, 2: transmitter timeout
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] data;
        int          enc_mode;  // 0: normal, 1: valid stuck high, 2: valid never
        int          uart_mode; // 0: normal, 1: busy never rises
        int          id;
        logic [3:0]  nib;
        bit          is_err;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hamming_uart_scheduler_if #(.NUM_REQ(NUM_REQ)) bus_if ();

    hamming_uart_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sched_bus (bus_if.slave)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    function automatic void check(string name, longint got, longint want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endfunction

    // ---------------- behavioural models ----------------
    int enc_mode  = 0;
    int uart_mode = 0;
    int busy_len  = 10;
    int enc_left  = 0;
    int busy_left = 0;
    bit enc_seen;
    bit txs_seen;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Encoder: valid rises one cycle after enc_ena and stays high for 3 cycles.
    always @(posedge clk) begin
        enc_seen = bus_if.enc_ena;
        #1;
        if (rst)           enc_left = 0;
        else if (enc_seen) enc_left = 3;
        else if (enc_left > 0) enc_left--;
        case (enc_mode)
            1:       bus_if.enc_valid = 1'b1;
            2:       bus_if.enc_valid = 1'b0;
            default: bus_if.enc_valid = (enc_left > 0);
        endcase
    end

    // Transmitter: busy for busy_len cycles after tx_start.
    always @(posedge clk) begin
        txs_seen = bus_if.tx_start;
        #1;
        if (rst)                              busy_left = 0;
        else if (txs_seen && uart_mode == 0)  busy_left = busy_len;
        else if (busy_left > 0)               busy_left--;
        bus_if.tx_busy = (busy_left > 0);
    end

    // ---------------- monitor / scoreboard ----------------
    int   done_cnt      = 0;
    int   ack_total     = 0;
    int   ena_cyc       = 0;
    int   txs_cyc       = 0;
    int   txs_cnt       = 0;
    int   last_busy_cyc = 0;
    int   last_done_cyc = -1;
    bit   gap_exact     = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            last_done_cyc = -1;
            txs_cnt       = 0;
        end else begin
            if (bus_if.tx_busy) last_busy_cyc = cyc;
            if (bus_if.tx_start) begin
                txs_cyc = cyc;
                txs_cnt++;
            end
            if (bus_if.enc_ena) begin
                ena_cyc = cyc;
                txs_cnt = 0;
                if (sb.size() == 0) begin
                    check("unexpected_grant", 1, 0);
                end else begin
                    check("grant_id", bus_if.grant_id, sb[0].id);
                    check("enc_data_at_grant", bus_if.enc_data, sb[0].nib);
                    if (gap_exact && last_done_cyc >= 0)
                        check("gap_to_next_grant", cyc - last_done_cyc, GAP_CYCLES + 1);
                end
            end
            if ((bus_if.ack | bus_if.err) != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack_err", {bus_if.ack, bus_if.err}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_bits", bus_if.ack, mon_e.is_err ? 0 : (1 << mon_e.id));
                    check("err_bits", bus_if.err, mon_e.is_err ? (1 << mon_e.id) : 0);
                    check("enc_data_held", bus_if.enc_data, mon_e.nib);
                    case (mon_e.lat)
                        1: begin
                            check("valid_timeout_latency", cyc - ena_cyc, TIMEOUT + 1);
                            check("no_tx_start_on_enc_timeout", txs_cnt, 0);
                        end
                        2:       check("busy_timeout_latency", cyc - txs_cyc, TIMEOUT + 1);
                        default: check("ack_after_busy_fall", cyc - last_busy_cyc, 2);
                    endcase
                end
                ack_total += $countones(bus_if.ack);
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_done(int target, int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_completion_in_time", (done_cnt >= target) ? 1 : 0, 1);
        if (done_cnt < target) sb.delete();
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while (bus_if.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("return_to_idle_in_time", bus_if.busy, 0);
        @(negedge clk);
    endtask

    task automatic run_frame(logic [3:0] rq, logic [15:0] dat, int id, logic [3:0] nib,
                             bit is_err, int lat);
        exp_t e;
        int   target;
        e.id = id; e.nib = nib; e.is_err = is_err; e.lat = lat;
        sb.push_back(e);
        target          = done_cnt + 1;
        bus_if.req_data = dat;
        bus_if.req      = rq;
        wait_done(target, 300);
        bus_if.req      = '0;
        wait_idle(60);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus_if.req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic reset_outputs(string tag);
        check({tag, "_ack"},         bus_if.ack, 0);
        check({tag, "_err"},         bus_if.err, 0);
        check({tag, "_enc_ena"},     bus_if.enc_ena, 0);
        check({tag, "_enc_data"},    bus_if.enc_data, 0);
        check({tag, "_tx_start"},    bus_if.tx_start, 0);
        check({tag, "_grant_id"},    bus_if.grant_id, 0);
        check({tag, "_busy"},        bus_if.busy, 0);
        check({tag, "_frame_count"}, bus_if.frame_count, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t        tbl[9];
        exp_t        e;
        int          n;
        int          base_ack;
        int          target;
        logic [3:0]  nb;
        logic [15:0] dat;

        //             req      data      enc uart id nib  err lat
        tbl[0] = '{4'b0001, 16'h000B, 0, 0, 0, 4'hB, 1'b0, 0};
        tbl[1] = '{4'b1111, 16'h4321, 0, 0, 1, 4'h2, 1'b0, 0};
        tbl[2] = '{4'b1111, 16'h4321, 0, 0, 2, 4'h3, 1'b0, 0};
        tbl[3] = '{4'b0011, 16'h4321, 0, 0, 0, 4'h1, 1'b0, 0};
        tbl[4] = '{4'b1000, 16'hA000, 1, 0, 3, 4'hA, 1'b1, 1};
        tbl[5] = '{4'b0100, 16'h0C00, 0, 1, 2, 4'hC, 1'b1, 2};
        tbl[6] = '{4'b0010, 16'h00D0, 0, 0, 1, 4'hD, 1'b0, 0};
        tbl[7] = '{4'b1001, 16'h7006, 0, 0, 3, 4'h7, 1'b0, 0};
        tbl[8] = '{4'b1001, 16'h7006, 2, 0, 0, 4'h6, 1'b1, 1};

        bus_if.req      = '0;
        bus_if.req_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single requester, minimum-latency timing
        e = '{0, 4'hB, 1'b0, 0};
        sb.push_back(e);
        target          = done_cnt + 1;
        bus_if.req_data = 16'h000B;
        bus_if.req      = 4'b0001;
        @(negedge clk);
        check("t1_enc_ena_after_grant", bus_if.enc_ena, 1);
        check("t1_busy_after_grant", bus_if.busy, 1);
        check("t1_tx_start_not_early", bus_if.tx_start, 0);
        @(negedge clk);
        check("t1_enc_ena_single_pulse", bus_if.enc_ena, 0);
        check("t1_tx_start_not_early2", bus_if.tx_start, 0);
        @(negedge clk);
        check("t1_tx_start", bus_if.tx_start, 1);
        wait_done(target, 200);
        bus_if.req = '0;
        wait_idle(60);
        check("t1_frame_count", bus_if.frame_count, 1);

        // Fairness: all four requesting, each drops on its own ack
        do_reset();
        for (int k = 0; k < 4; k++) begin
            e = '{k, 4'(k + 1), 1'b0, 0};
            sb.push_back(e);
        end
        gap_exact       = 1'b1;
        base_ack        = ack_total;
        bus_if.req_data = 16'h4321;
        bus_if.req      = 4'b1111;
        n = 0;
        while (bus_if.req != '0 && n < 400) begin
            @(negedge clk);
            bus_if.req = bus_if.req & ~bus_if.ack;
            n++;
        end
        check("fair_all_served", bus_if.req, 0);
        wait_idle(60);
        gap_exact = 1'b0;
        check("fair_ack_count", ack_total - base_ack, 4);
        check("fair_frame_count", bus_if.frame_count, 4);
        check("fair_queue_drained", sb.size(), 0);

        // Table-driven vectors: arbitration, timeouts, recovery
        foreach (tbl[i]) begin
            enc_mode  = tbl[i].enc_mode;
            uart_mode = tbl[i].uart_mode;
            repeat (3) @(negedge clk);
            run_frame(tbl[i].req, tbl[i].data, tbl[i].id, tbl[i].nib, tbl[i].is_err, tbl[i].lat);
            enc_mode  = 0;
            uart_mode = 0;
            repeat (4) @(negedge clk);
        end
        check("table_frame_count", bus_if.frame_count, 10);

        // Reset while waiting for the transmitter to finish
        e = '{0, 4'h5, 1'b0, 0};
        sb.push_back(e);
        bus_if.req_data = 16'h0005;
        bus_if.req      = 4'b0001;
        n = 0;
        while (!bus_if.tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrst_tx_busy_reached", bus_if.tx_busy, 1);
        repeat (2) @(negedge clk);
        rst        = 1'b1;
        bus_if.req = '0;
        @(negedge clk);
        reset_outputs("midrst");
        rst = 1'b0;
        sb.delete();
        repeat (15) @(negedge clk);
        run_frame(4'b0100, 16'h0E00, 2, 4'hE, 1'b0, 0);
        check("midrst_next_frame_count", bus_if.frame_count, 1);

        // Counter wrap after 256 successful frames
        do_reset();
        busy_len = 2;
        base_ack = ack_total;
        for (int k = 0; k < 256; k++) begin
            nb  = 4'(k);
            dat = {12'h000, nb} << (4 * (k % 4));
            run_frame(4'(1 << (k % 4)), dat, k % 4, nb, 1'b0, 0);
            if (k == 254) check("wrap_count_255", bus_if.frame_count, 255);
        end
        check("wrap_count_zero", bus_if.frame_count, 0);
        check("wrap_ack_total", ack_total - base_ack, 256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound on the run
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
